// File: rtl/sata_phy_pkg.sv
// sata_phy_pkg: state encoding and default timing constants for the GTX reset sequencer
package sata_phy_pkg;

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_CPLL_RST  = 4'd1,
    S_WAIT_LOCK = 4'd2,
    S_PMA_RST   = 4'd3,
    S_WAIT_USR  = 4'd4,
    S_WAIT_DONE = 4'd5,
    S_READY     = 4'd6,
    S_RX_RST    = 4'd7,
    S_RX_WAIT   = 4'd8
  } state_t;

  localparam int CPLLRST_TIME_D    = 8;
  localparam int TXPMARESET_TIME_D = 1;
  localparam int RXEYERESET_TIME_D = 35;
  localparam int RXRST_TIME_D      = 8;
  localparam int LOCK_TIMEOUT_D    = 4095;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sata_sync2.sv
// sata_sync2: two-flop synchronizer into the gtrefclk domain, cleared by extrst
module sata_sync2 (
  input  logic gtrefclk,
  input  logic extrst,
  input  logic d,
  output logic q
);

  logic [1:0] r;

  // shift the async level through two flops
  always_ff @(posedge gtrefclk or posedge extrst)
    if (extrst) r <= '0;
    else r <= {r[0], d};

  assign q = r[1];

endmodule

// File: rtl/gtx_rst_seq.sv
// gtx_rst_seq: GTX CPLL/PMA/userrdy reset sequencer with OOB RX reset handshake; GTX_RST_SEQ_TIMEOUT_EN enables lock/done timeout retries
module gtx_rst_seq
  import sata_phy_pkg::*;
#(
  parameter int CPLLRST_TIME    = CPLLRST_TIME_D,
  parameter int TXPMARESET_TIME = TXPMARESET_TIME_D,
  parameter int RXEYERESET_TIME = RXEYERESET_TIME_D,
  parameter int RXRST_TIME      = RXRST_TIME_D,
  parameter int LOCK_TIMEOUT    = LOCK_TIMEOUT_D
) (
  input  logic       gtrefclk,
  input  logic       extrst,
  input  logic       cplllock,
  input  logic       usrpll_locked,
  input  logic       txresetdone,
  input  logic       rxresetdone,
  input  logic       rxreset_req,
  output logic       cpllreset,
  output logic       txreset,
  output logic       rxreset,
  output logic       txuserrdy,
  output logic       rxuserrdy,
  output logic       gtx_ready,
  output logic       rxreset_ack,
  output logic [3:0] state,
  output logic [7:0] retry_cnt
);

`ifdef GTX_RST_SEQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam logic [8:0]  T_CPLL  = 9'(CPLLRST_TIME);
  localparam logic [8:0]  T_PMA   = 9'(max2(TXPMARESET_TIME, RXEYERESET_TIME));
  localparam logic [8:0]  T_EYE   = 9'(RXEYERESET_TIME);
  localparam logic [8:0]  T_RXRST = 9'(RXRST_TIME);
  localparam logic [16:0] T_LOCK  = 17'(LOCK_TIMEOUT);

  state_t      st, st_n;
  logic [4:0]  a_in, s;
  logic        lock_s, usr_s, txdone_s, rxdone_s, req_s;
  logic [7:0]  cnt, retry;
  logic [8:0]  elapsed;
  logic [15:0] tmr;
  logic        tmo, retry_inc;

  assign a_in = {rxreset_req, rxresetdone, txresetdone, usrpll_locked, cplllock};
  assign {req_s, rxdone_s, txdone_s, usr_s, lock_s} = s;

  for (genvar i = 0; i < 5; i++) begin : g_sync
    sata_sync2 u_sync (.gtrefclk(gtrefclk), .extrst(extrst), .d(a_in[i]), .q(s[i]));
  end

  assign elapsed   = {1'b0, cnt} + 9'd1;
  assign tmo       = TMO_EN && (({1'b0, tmr} + 17'd1) >= T_LOCK);
  assign retry_inc = (st_n == S_CPLL_RST) && ((st == S_WAIT_LOCK) || (st == S_WAIT_DONE && lock_s));
  assign state     = st;
  assign retry_cnt = retry;

  // next-state decode; lock loss from PMA_RST onward overrides every other exit
  always_comb begin
    st_n = st;
    case (st)
      S_RESET:     st_n = S_CPLL_RST;
      S_CPLL_RST:  st_n = (elapsed >= T_CPLL) ? S_WAIT_LOCK : st;
      S_WAIT_LOCK: st_n = lock_s ? S_PMA_RST : (tmo ? S_CPLL_RST : st);
      S_PMA_RST:   st_n = (elapsed >= T_PMA) ? S_WAIT_USR : st;
      S_WAIT_USR:  st_n = usr_s ? S_WAIT_DONE : st;
      S_WAIT_DONE: st_n = (txdone_s && rxdone_s) ? S_READY : (tmo ? S_CPLL_RST : st);
      S_READY:     st_n = (req_s && !rxreset_ack) ? S_RX_RST : st;
      S_RX_RST:    st_n = (elapsed >= T_RXRST) ? S_RX_WAIT : st;
      S_RX_WAIT:   st_n = (elapsed >= T_EYE && rxdone_s) ? S_READY : st;
      default:     st_n = S_RESET;
    endcase
    if (st >= S_PMA_RST && st <= S_RX_WAIT && !lock_s) st_n = S_CPLL_RST;
  end

  // state, per-state counters and outputs registered from the next state
  always_ff @(posedge gtrefclk or posedge extrst)
    if (extrst) begin
      st          <= S_RESET;
      cnt         <= '0;
      tmr         <= '0;
      retry       <= '0;
      cpllreset   <= 1'b1;
      txreset     <= 1'b1;
      rxreset     <= 1'b1;
      txuserrdy   <= 1'b0;
      rxuserrdy   <= 1'b0;
      gtx_ready   <= 1'b0;
      rxreset_ack <= 1'b0;
    end else begin
      st          <= st_n;
      cnt         <= (st_n != st) ? '0 : cnt + 8'(cnt != 8'hff);
      tmr         <= (st_n != st) ? '0 : tmr + 16'(tmr != 16'hffff);
      retry       <= retry + 8'(retry_inc && retry != 8'hff);
      cpllreset   <= st_n inside {S_RESET, S_CPLL_RST};
      txreset     <= st_n inside {S_RESET, S_CPLL_RST, S_WAIT_LOCK};
      rxreset     <= st_n inside {S_RESET, S_CPLL_RST, S_WAIT_LOCK, S_RX_RST};
      txuserrdy   <= st_n inside {S_WAIT_DONE, S_READY, S_RX_RST, S_RX_WAIT};
      rxuserrdy   <= st_n inside {S_WAIT_DONE, S_READY, S_RX_WAIT};
      gtx_ready   <= st_n == S_READY;
      rxreset_ack <= req_s && (rxreset_ack || (st == S_RX_WAIT && st_n == S_READY));
    end

endmodule
